// File: rtl/bootstrap_loader_if.sv
// Bus bundle between the board-level byte source and bootstrap_loader.
// Carries the valid/ready byte stream plus the microcode store bootstrap
// write port and the boot status outputs.
//   master : byte source side (drives in_data/in_valid, observes the rest)
//   slave  : loader side (consumes the stream, drives store port and status)
interface bootstrap_loader_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] bootstrap_addr;
  logic [7:0]            bootstrap_data;
  logic                  bootstrap_n_we;
  logic                  n_booted;
  logic                  core_n_rst;
  logic                  boot_err;

  modport master (
    output in_data, in_valid,
    input  in_ready, bootstrap_addr, bootstrap_data, bootstrap_n_we,
           n_booted, core_n_rst, boot_err
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, bootstrap_addr, bootstrap_data, bootstrap_n_we,
           n_booted, core_n_rst, boot_err
  );
endinterface

// File: rtl/bootstrap_loader.sv
// Power-on microcode loader: accepts LENGTH payload bytes from a valid/ready
// stream, writes each to the store bootstrap port with a SETUP/WRITE/HOLD
// strobe sequence, then checks a trailing mod-256 checksum byte.
// On success drops n_booted, then releases core_n_rst one cycle later.
// On mismatch enters a sticky error state.
// Ports: clk, rst (async, active-high), bus (slave modport of
// bootstrap_loader_if). All bus outputs are registered except in_ready,
// which decodes the state.
module bootstrap_loader #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LENGTH     = 4096,
  parameter int unsigned WE_LOW     = 1
) (
  input  logic               clk,
  input  logic               rst,
  bootstrap_loader_if.slave  bus
);

  localparam int unsigned           CNT_W     = (WE_LOW > 1) ? $clog2(WE_LOW) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LENGTH - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(WE_LOW - 1);

  typedef enum logic [2:0] {
    WAIT_BYTE,
    SETUP,
    WRITE,
    HOLD,
    WAIT_SUM,
    DONE,
    ERROR
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr, addr_next;
  logic [7:0]            sum, sum_next;
  logic [7:0]            data, data_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic                  n_we, n_we_next;
  logic                  n_booted, n_booted_next;
  logic                  core_n_rst, core_n_rst_next;
  logic                  boot_err, boot_err_next;
  logic [7:0]            sum_chk;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_BYTE;
      addr       <= '0;
      sum        <= '0;
      data       <= '0;
      cnt        <= '0;
      n_we       <= 1'b1;
      n_booted   <= 1'b1;
      core_n_rst <= 1'b0;
      boot_err   <= 1'b0;
    end else begin
      state      <= state_next;
      addr       <= addr_next;
      sum        <= sum_next;
      data       <= data_next;
      cnt        <= cnt_next;
      n_we       <= n_we_next;
      n_booted   <= n_booted_next;
      core_n_rst <= core_n_rst_next;
      boot_err   <= boot_err_next;
    end
  end

  assign sum_chk = sum + bus.in_data;

  // Next state, datapath and next output values
  always_comb begin
    state_next = state;
    addr_next  = addr;
    sum_next   = sum;
    data_next  = data;
    cnt_next   = cnt;

    case (state)
      WAIT_BYTE: begin
        if (bus.in_valid) begin
          data_next  = bus.in_data;
          sum_next   = sum_chk;
          state_next = SETUP;
        end
      end
      SETUP: begin
        cnt_next   = '0;
        state_next = WRITE;
      end
      WRITE: begin
        if (cnt == CNT_LAST) begin
          state_next = HOLD;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        // Last address is terminal, so the address never wraps
        if (addr == LAST_ADDR) begin
          state_next = WAIT_SUM;
        end else begin
          addr_next  = addr + ADDR_WIDTH'(1);
          state_next = WAIT_BYTE;
        end
      end
      WAIT_SUM: begin
        if (bus.in_valid) begin
          state_next = (sum_chk == 8'h00) ? DONE : ERROR;
        end
      end
      DONE:    state_next = DONE;
      ERROR:   state_next = ERROR;
      default: state_next = ERROR;
    endcase

    // Outputs are decoded from the upcoming state so the flops align with it
    n_we_next       = (state_next != WRITE);
    n_booted_next   = (state_next != DONE);
    core_n_rst_next = (state == DONE);
    boot_err_next   = (state_next == ERROR);
  end

  assign bus.in_ready       = !rst && ((state == WAIT_BYTE) || (state == WAIT_SUM));
  assign bus.bootstrap_addr = addr;
  assign bus.bootstrap_data = data;
  assign bus.bootstrap_n_we = n_we;
  assign bus.n_booted       = n_booted;
  assign bus.core_n_rst     = core_n_rst;
  assign bus.boot_err       = boot_err;

endmodule

// File: tb/tb_bootstrap_loader.sv
// Self-checking bench for bootstrap_loader. Three instances cover
// LENGTH=4/WE_LOW=1, LENGTH=4/WE_LOW=3 and LENGTH=4096/WE_LOW=1; one is
// active at a time. A transaction-level model predicts every output each
// cycle from the count of accepted bytes and the cycles since the last one.
module tb_bootstrap_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  int unsigned sel = 0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;

  bootstrap_loader_if #(.ADDR_WIDTH(4))  if0 ();
  bootstrap_loader_if #(.ADDR_WIDTH(4))  if1 ();
  bootstrap_loader_if #(.ADDR_WIDTH(12)) if2 ();

  assign if0.in_valid = in_valid && (sel == 0);
  assign if1.in_valid = in_valid && (sel == 1);
  assign if2.in_valid = in_valid && (sel == 2);
  assign if0.in_data  = in_data;
  assign if1.in_data  = in_data;
  assign if2.in_data  = in_data;

  bootstrap_loader #(.ADDR_WIDTH(4), .LENGTH(4), .WE_LOW(1)) u0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  bootstrap_loader #(.ADDR_WIDTH(4), .LENGTH(4), .WE_LOW(3)) u1 (
    .clk(clk), .rst(rst), .bus(if1.slave));
  bootstrap_loader #(.ADDR_WIDTH(12), .LENGTH(4096), .WE_LOW(1)) u2 (
    .clk(clk), .rst(rst), .bus(if2.slave));

  // Outputs of the active instance
  logic        m_ready, m_n_we, m_n_booted, m_core, m_err;
  logic [11:0] m_addr;
  logic [7:0]  m_data;

  always_comb begin
    case (sel)
      0: begin
        m_ready = if0.in_ready; m_addr = 12'(if0.bootstrap_addr);
        m_data = if0.bootstrap_data; m_n_we = if0.bootstrap_n_we;
        m_n_booted = if0.n_booted; m_core = if0.core_n_rst; m_err = if0.boot_err;
      end
      1: begin
        m_ready = if1.in_ready; m_addr = 12'(if1.bootstrap_addr);
        m_data = if1.bootstrap_data; m_n_we = if1.bootstrap_n_we;
        m_n_booted = if1.n_booted; m_core = if1.core_n_rst; m_err = if1.boot_err;
      end
      default: begin
        m_ready = if2.in_ready; m_addr = if2.bootstrap_addr;
        m_data = if2.bootstrap_data; m_n_we = if2.bootstrap_n_we;
        m_n_booted = if2.n_booted; m_core = if2.core_n_rst; m_err = if2.boot_err;
      end
    endcase
  end

  int len = 4;
  int wel = 1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: bytes accepted, running sum, last payload byte, cycles since last accept
  int mk = 0, msum = 0, mdata = 0, msince = 1000;
  bit mdone = 0, merr = 0;

  function automatic bit m_busy();
    return (mk > 0) && !mdone && !merr && (msince <= wel + 2);
  endfunction

  function automatic bit m_exp_ready();
    return !m_busy() && !mdone && !merr;
  endfunction

  function automatic bit m_exp_n_we();
    return !(m_busy() && (msince >= 2) && (msince <= wel + 1));
  endfunction

  function automatic int m_exp_addr();
    if (m_busy()) return mk - 1;
    return (mk < len) ? mk : len - 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mk = 0; msum = 0; mdata = 0; msince = 1000; mdone = 0; merr = 0;
    end else begin
      if (in_valid && m_exp_ready()) begin
        if (mk < len) begin
          mdata = int'(in_data);
          msum  = (msum + int'(in_data)) % 256;
          mk++;
        end else if (((msum + int'(in_data)) % 256) == 0) begin
          mdone = 1;
        end else begin
          merr = 1;
        end
        msince = 0;
      end
      if (msince < 1000) msince++;
    end
  end

  // Write pulse log for literal checks
  int p_addr[$];
  int p_data[$];
  int p_cyc[$];
  int p_w[$];
  bit prev_n_we = 1'b1;
  int wcnt = 0;

  task automatic clear_log();
    p_addr.delete(); p_data.delete(); p_cyc.delete(); p_w.delete();
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check("rst_in_ready", 32'(m_ready), 0);
      check("rst_n_we", 32'(m_n_we), 1);
      check("rst_addr", 32'(m_addr), 0);
      check("rst_data", 32'(m_data), 0);
      check("rst_n_booted", 32'(m_n_booted), 1);
      check("rst_core_n_rst", 32'(m_core), 0);
      check("rst_boot_err", 32'(m_err), 0);
      prev_n_we = 1'b1;
    end else begin
      check("in_ready", 32'(m_ready), 32'(m_exp_ready()));
      check("n_we", 32'(m_n_we), 32'(m_exp_n_we()));
      check("addr", 32'(m_addr), 32'(m_exp_addr()));
      check("data", 32'(m_data), 32'(mdata));
      check("n_booted", 32'(m_n_booted), 32'(!mdone));
      check("core_n_rst", 32'(m_core), 32'(mdone && (msince >= 2)));
      check("boot_err", 32'(m_err), 32'(merr));
      if (prev_n_we && !m_n_we) begin
        p_addr.push_back(int'(m_addr));
        p_data.push_back(int'(m_data));
        p_cyc.push_back(cyc);
        wcnt = 1;
      end else if (!m_n_we) begin
        wcnt++;
      end else if (!prev_n_we) begin
        p_w.push_back(wcnt);
      end
      prev_n_we = m_n_we;
    end
  end

  logic [7:0] stream[$];
  bit hit_stop = 0;

  task automatic do_reset(input int unsigned s);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    sel = s;
    len = (s == 2) ? 4096 : 4;
    wel = (s == 1) ? 3 : 1;
    repeat (3) @(posedge clk);
    #1;
    clear_log();
    rst = 1'b0;
  endtask

  // Offers the stream bytes; optionally asserts rst mid-write at stop_addr
  task automatic run_stream(input bit rand_valid, input int stop_addr);
    int  idx = 0;
    bit  tr = 0;
    int  budget = 0;
    while (idx < stream.size() && budget < 40000) begin
      @(posedge clk); #1;
      if (tr) idx++;
      tr = 0;
      if (idx >= stream.size()) break;
      in_valid = rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? stream[idx] : 8'($urandom);
      @(negedge clk); #2;
      tr = in_valid && m_ready;
      if (stop_addr >= 0 && !m_n_we && m_addr == 12'(stop_addr)) begin
        rst = 1'b1;
        #1;
        check("async_n_we_on_rst", 32'(m_n_we), 1);
        hit_stop = 1;
        in_valid = 1'b0;
        return;
      end
      budget++;
    end
    in_valid = 1'b0;
    check("stream_complete", 32'(idx), 32'(stream.size()));
  endtask

  task automatic make_random_stream();
    int s = 0;
    stream.delete();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      stream.push_back(b);
      s += int'(b);
    end
    stream.push_back(8'(256 - (s % 256)));
  endtask

  task automatic hold_valid_after_end();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk); #2;
      check("terminal_in_ready", 32'(m_ready), 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    @(negedge clk); #2;
  endtask

  initial begin
    // Test 1: LENGTH=4, WE_LOW=1, good checksum, valid always high
    do_reset(0);
    stream.delete();
    stream.push_back(8'h11); stream.push_back(8'h22); stream.push_back(8'h33);
    stream.push_back(8'h44); stream.push_back(8'h56);
    run_stream(0, -1);
    settle();
    check("t1_pulses", 32'(p_addr.size()), 4);
    if (p_addr.size() == 4) begin
      check("t1_addr0", 32'(p_addr[0]), 0);
      check("t1_addr3", 32'(p_addr[3]), 3);
      check("t1_data0", 32'(p_data[0]), 32'h11);
      check("t1_data1", 32'(p_data[1]), 32'h22);
      check("t1_data2", 32'(p_data[2]), 32'h33);
      check("t1_data3", 32'(p_data[3]), 32'h44);
      for (int i = 1; i < 4; i++) check("t1_byte_period", 32'(p_cyc[i] - p_cyc[i-1]), 4);
    end
    foreach (p_w[i]) check("t1_pulse_width", 32'(p_w[i]), 1);
    check("t1_n_booted", 32'(m_n_booted), 0);
    check("t1_core_n_rst", 32'(m_core), 1);
    check("t1_boot_err", 32'(m_err), 0);
    hold_valid_after_end();
    check("t1_post_pulses", 32'(p_addr.size()), 4);
    check("t1_post_n_booted", 32'(m_n_booted), 0);

    // Test 2: bad checksum
    do_reset(0);
    stream[4] = 8'h57;
    run_stream(0, -1);
    settle();
    check("t2_boot_err", 32'(m_err), 1);
    check("t2_n_booted", 32'(m_n_booted), 1);
    check("t2_core_n_rst", 32'(m_core), 0);
    hold_valid_after_end();
    check("t2_post_boot_err", 32'(m_err), 1);

    // Test 3: WE_LOW=3 with random valid stalls
    for (int rep = 0; rep < 3; rep++) begin
      do_reset(1);
      make_random_stream();
      run_stream(1, -1);
      settle();
      check("t3_pulses", 32'(p_addr.size()), 4);
      foreach (p_w[i]) check("t3_pulse_width", 32'(p_w[i]), 3);
      for (int i = 0; i < p_addr.size() && i < 4; i++) begin
        check("t3_addr", 32'(p_addr[i]), 32'(i));
        check("t3_data", 32'(p_data[i]), 32'(stream[i]));
      end
      check("t3_n_booted", 32'(m_n_booted), 0);
    end

    // Test 4: reset during the write at addr 2, then a fresh load
    do_reset(0);
    make_random_stream();
    hit_stop = 0;
    run_stream(0, 2);
    check("t4_reset_hit", 32'(hit_stop), 1);
    do_reset(0);
    make_random_stream();
    run_stream(0, -1);
    settle();
    check("t4_pulses", 32'(p_addr.size()), 4);
    if (p_addr.size() > 0) check("t4_first_addr", 32'(p_addr[0]), 0);
    check("t4_n_booted", 32'(m_n_booted), 0);
    check("t4_boot_err", 32'(m_err), 0);

    // Test 5: full 4096-byte image, data = addr[7:0]
    do_reset(2);
    begin
      int s = 0;
      stream.delete();
      for (int i = 0; i < 4096; i++) begin
        stream.push_back(8'(i));
        s += i % 256;
      end
      stream.push_back(8'(256 - (s % 256)));
    end
    run_stream(0, -1);
    settle();
    check("t5_pulses", 32'(p_addr.size()), 4096);
    if (p_addr.size() == 4096) begin
      check("t5_last_addr", 32'(p_addr[4095]), 32'hFFF);
      check("t5_last_data", 32'(p_data[4095]), 32'hFF);
    end
    check("t5_final_addr", 32'(m_addr), 32'hFFF);
    check("t5_n_booted", 32'(m_n_booted), 0);
    check("t5_core_n_rst", 32'(m_core), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
